// File: rtl/stream_packetizer.sv
// ---------------------------------------------------------------------------
// stream_packetizer
//   Drains bytes from a FIFO read port into a small payload buffer and emits
//   them as a framed packet on a valid/ready byte stream:
//       SYNC_BYTE, LEN, payload[0..LEN-1], CHK
//   CHK = (LEN + sum of payload bytes) mod 2^DATA_WIDTH, flagged with m_last.
//   A packet closes when the buffer is full, on a flush pulse (with at least
//   one byte buffered or a read in flight), or after TIMEOUT_CYC idle cycles
//   with a partially filled buffer.
//
// Ports
//   clk           in   clock, rising edge
//   rst           in   synchronous reset, active-high
//   fifo_rd_en    out  read strobe to the FIFO (data returns next cycle)
//   fifo_rd_data  in   FIFO read data
//   fifo_empty    in   FIFO empty flag
//   flush         in   pulse: close the current partial packet
//   m_data        out  output byte
//   m_valid       out  output byte valid
//   m_ready       in   downstream accept
//   m_last        out  high with the CHK byte
//   busy          out  high while a packet is being sent
//   pkt_count     out  completed packets, wraps at 2^16
// ---------------------------------------------------------------------------
module stream_packetizer #(
    parameter int                    DATA_WIDTH  = 8,
    parameter int                    PKT_LEN     = 4,
    parameter int                    TIMEOUT_CYC = 16,
    parameter logic [DATA_WIDTH-1:0] SYNC_BYTE   = 8'hA5
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                  fifo_empty,
    input  logic                  flush,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
    output logic                  busy,
    output logic [15:0]           pkt_count
);

    localparam int LEN_W = $clog2(PKT_LEN + 1);
    localparam int TMR_W = $clog2(TIMEOUT_CYC);
    // Buffer depth is rounded up to a power of two so the fill counter
    // indexes it without a width mismatch; entries past PKT_LEN stay unused.
    localparam int BUF_D = 1 << LEN_W;

    typedef enum logic [2:0] {
        ST_FILL      = 3'd0,
        ST_SEND_SYNC = 3'd1,
        ST_SEND_LEN  = 3'd2,
        ST_SEND_PAY  = 3'd3,
        ST_SEND_CHK  = 3'd4
    } state_t;

    state_t                r_state;
    logic [LEN_W-1:0]      r_fill_cnt;
    logic                  r_pending;
    logic                  r_closing;
    logic [TMR_W-1:0]      r_timer;
    logic [DATA_WIDTH-1:0] r_chk;
    logic [LEN_W-1:0]      r_idx;
    logic [DATA_WIDTH-1:0] r_buf [BUF_D];
    logic [DATA_WIDTH-1:0] r_m_data;
    logic                  r_m_valid;
    logic                  r_m_last;
    logic                  r_busy;
    logic [15:0]           r_pkt_count;

    logic [LEN_W-1:0]      w_occupancy;
    logic                  w_close;
    logic                  w_rd_en;
    logic                  w_accept;
    logic [DATA_WIDTH-1:0] w_len_byte;
    logic [DATA_WIDTH-1:0] w_chk_byte;

    // Close request, FIFO read strobe and the derived LEN/CHK bytes.
    always_comb begin
        w_occupancy = r_fill_cnt + LEN_W'(r_pending);
        // A latched close (r_closing) or a flush during an in-flight read
        // still counts as closing so no further read is issued.
        w_close = r_closing
               || (r_fill_cnt == LEN_W'(PKT_LEN))
               || (flush && ((r_fill_cnt != {LEN_W{1'b0}}) || r_pending))
               || (r_timer == TMR_W'(TIMEOUT_CYC - 1));
        // Combinational so the strobe follows fifo_empty in the same cycle
        // and can never pop an empty FIFO.
        if (!rst && (r_state == ST_FILL) && !fifo_empty
                 && (w_occupancy < LEN_W'(PKT_LEN)) && !w_close) begin
            w_rd_en = 1'b1;
        end else begin
            w_rd_en = 1'b0;
        end
        w_accept   = r_m_valid && m_ready;
        w_len_byte = DATA_WIDTH'(r_fill_cnt);
        w_chk_byte = r_chk + w_len_byte;
    end

    // Packetizer FSM: buffer fill, close decision and framed byte output.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_FILL;
            r_fill_cnt  <= {LEN_W{1'b0}};
            r_pending   <= 1'b0;
            r_closing   <= 1'b0;
            r_timer     <= {TMR_W{1'b0}};
            r_chk       <= {DATA_WIDTH{1'b0}};
            r_idx       <= {LEN_W{1'b0}};
            r_m_data    <= {DATA_WIDTH{1'b0}};
            r_m_valid   <= 1'b0;
            r_m_last    <= 1'b0;
            r_busy      <= 1'b0;
            r_pkt_count <= 16'd0;
        end else begin
            case (r_state)
                ST_FILL: begin
                    if (r_pending) begin
                        r_buf[r_fill_cnt] <= fifo_rd_data;
                        r_fill_cnt        <= r_fill_cnt + LEN_W'(1);
                        r_chk             <= r_chk + fifo_rd_data;
                    end
                    r_pending <= w_rd_en;
                    if (r_pending || (r_fill_cnt == {LEN_W{1'b0}})) begin
                        r_timer <= {TMR_W{1'b0}};
                    end else if (!w_rd_en) begin
                        r_timer <= r_timer + TMR_W'(1);
                    end else begin
                        r_timer <= r_timer;
                    end
                    // Closing waits for an in-flight capture to land first.
                    if (w_close) begin
                        if (r_pending) begin
                            r_closing <= 1'b1;
                        end else begin
                            r_closing <= 1'b0;
                            r_timer   <= {TMR_W{1'b0}};
                            r_busy    <= 1'b1;
                            r_state   <= ST_SEND_SYNC;
                        end
                    end
                end
                ST_SEND_SYNC: begin
                    // First cycle presents SYNC; each accept preloads the next
                    // byte so the stream has no bubbles.
                    if (!r_m_valid) begin
                        r_m_valid <= 1'b1;
                        r_m_data  <= SYNC_BYTE;
                    end else if (m_ready) begin
                        r_m_data <= w_len_byte;
                        r_state  <= ST_SEND_LEN;
                    end
                end
                ST_SEND_LEN: begin
                    if (w_accept) begin
                        r_m_data <= r_buf[{LEN_W{1'b0}}];
                        r_idx    <= LEN_W'(1);
                        r_state  <= ST_SEND_PAY;
                    end
                end
                ST_SEND_PAY: begin
                    if (w_accept) begin
                        if (r_idx == r_fill_cnt) begin
                            r_m_data <= w_chk_byte;
                            r_m_last <= 1'b1;
                            r_state  <= ST_SEND_CHK;
                        end else begin
                            r_m_data <= r_buf[r_idx];
                            r_idx    <= r_idx + LEN_W'(1);
                        end
                    end
                end
                ST_SEND_CHK: begin
                    if (w_accept) begin
                        r_m_valid   <= 1'b0;
                        r_m_last    <= 1'b0;
                        r_m_data    <= {DATA_WIDTH{1'b0}};
                        r_pkt_count <= r_pkt_count + 16'd1;
                        r_fill_cnt  <= {LEN_W{1'b0}};
                        r_chk       <= {DATA_WIDTH{1'b0}};
                        r_busy      <= 1'b0;
                        r_state     <= ST_FILL;
                    end
                end
                default: begin
                    r_state <= ST_FILL;
                end
            endcase
        end
    end

    assign fifo_rd_en = w_rd_en;
    assign m_data     = r_m_data;
    assign m_valid    = r_m_valid;
    assign m_last     = r_m_last;
    assign busy       = r_busy;
    assign pkt_count  = r_pkt_count;

endmodule

// File: tb/tb_stream_packetizer.sv
// ---------------------------------------------------------------------------
// tb_stream_packetizer
//   Directed and randomized stimulus for stream_packetizer. A behavioural
//   FIFO feeds the DUT; every burst of bytes written to the FIFO is turned
//   into its expected framed packets (chunks of PKT_LEN, trailing partial
//   chunk closed by timeout or flush) and compared byte by byte with what
//   the DUT hands over on the valid/ready stream.
// ---------------------------------------------------------------------------
module tb_stream_packetizer;

    localparam int         PKT_LEN = 4;
    localparam int         TMO     = 16;
    localparam logic [7:0] SYNC    = 8'hA5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fifo_rd_en;
    logic [7:0]  fifo_rd_data = 8'h00;
    logic        fifo_empty;
    logic        flush = 1'b0;
    logic [7:0]  m_data;
    logic        m_valid;
    logic        m_ready = 1'b1;
    logic        m_last;
    logic        busy;
    logic [15:0] pkt_count;

    int n_checks = 0;
    int n_fail   = 0;

    // FIFO model storage and counters
    logic [7:0] fifo_mem [0:1023];
    int push_cnt   = 0;
    int pop_cnt    = 0;
    int empty_pops = 0;

    // Monitor state
    logic [8:0] got_q [$];
    logic [8:0] exp_q [$];
    logic [7:0] burst [$];
    int   exp_pkts    = 0;
    int   stable_seen = 0;
    int   rd_in_send  = 0;
    int   rd_empty    = 0;
    bit   prev_stall  = 1'b0;
    logic [7:0] prev_d = 8'h00;
    logic       prev_l = 1'b0;

    stream_packetizer #(
        .DATA_WIDTH (8),
        .PKT_LEN    (PKT_LEN),
        .TIMEOUT_CYC(TMO),
        .SYNC_BYTE  (SYNC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .fifo_rd_en  (fifo_rd_en),
        .fifo_rd_data(fifo_rd_data),
        .fifo_empty  (fifo_empty),
        .flush       (flush),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_last      (m_last),
        .busy        (busy),
        .pkt_count   (pkt_count)
    );

    always #5 clk = ~clk;

    assign fifo_empty = (push_cnt == pop_cnt);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // FIFO read port: data appears the cycle after the strobe.
    always @(posedge clk) begin
        if (fifo_rd_en) begin
            if (push_cnt == pop_cnt) begin
                empty_pops <= empty_pops + 1;
            end else begin
                fifo_rd_data <= fifo_mem[pop_cnt % 1024];
                pop_cnt      <= pop_cnt + 1;
            end
        end
    end

    // Output monitor: records accepted bytes, checks hold-under-stall.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                stable_seen++;
                chk("hold_valid", m_valid, 1);
                chk("hold_data", m_data, prev_d);
                chk("hold_last", m_last, prev_l);
            end
            prev_stall = m_valid && !m_ready;
            prev_d     = m_data;
            prev_l     = m_last;
            if (m_valid && m_ready) got_q.push_back({m_last, m_data});
            if (busy && fifo_rd_en) rd_in_send++;
            if (fifo_rd_en && fifo_empty) rd_empty++;
        end
    end

    // Expected framing of burst[off +: len]
    task automatic model_pkt(input int off, input int len);
        logic [7:0] sum;
        sum = 8'(len);
        exp_q.push_back({1'b0, SYNC});
        exp_q.push_back({1'b0, 8'(len)});
        for (int i = 0; i < len; i++) begin
            exp_q.push_back({1'b0, burst[off + i]});
            sum = sum + burst[off + i];
        end
        exp_q.push_back({1'b1, sum});
        exp_pkts++;
    endtask

    // Write the burst into the FIFO at once and model its packets.
    task automatic send_burst();
        int off;
        int len;
        foreach (burst[i]) begin
            fifo_mem[push_cnt % 1024] = burst[i];
            push_cnt++;
        end
        off = 0;
        while (off < burst.size()) begin
            len = burst.size() - off;
            if (len > PKT_LEN) len = PKT_LEN;
            model_pkt(off, len);
            off += len;
        end
        burst.delete();
    endtask

    task automatic pulse_flush();
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
    endtask

    // Wait (bounded) for the expected bytes, then compare the streams.
    task automatic wait_stream(input string tag, input int bound, input bit rnd);
        int cyc;
        int n;
        cyc = 0;
        while (((got_q.size() < exp_q.size()) || busy) && (cyc < bound)) begin
            @(posedge clk); #1;
            if (rnd) m_ready = ($urandom_range(0, 3) != 0);
            cyc++;
        end
        m_ready = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
        end
        chk({tag, "_in_time"}, (cyc < bound), 1);
        chk({tag, "_len"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk({tag, "_byte"}, got_q[i], exp_q[i]);
        end
        got_q.delete();
        exp_q.delete();
        chk({tag, "_pkts"}, pkt_count, exp_pkts[15:0]);
    endtask

    initial begin
        int hold;
        int cyc;
        int n;
        int s0;

        // Reset state
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_last", m_last, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pkt_count", pkt_count, 0);
        chk("rst_rd_en", fifo_rd_en, 0);

        // Full packet
        @(posedge clk); #1;
        burst = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        send_burst();
        wait_stream("full", 40, 0);

        // Timeout close of a short packet
        burst = '{8'hE5, 8'hF6};
        send_burst();
        repeat (8) begin
            @(posedge clk); #1;
        end
        chk("tmo_not_early", busy, 0);
        wait_stream("tmo", 60, 0);

        // Flush after the byte has been captured
        burst = '{8'h3C};
        send_burst();
        repeat (3) begin
            @(posedge clk); #1;
        end
        pulse_flush();
        wait_stream("flush", 12, 0);

        // Flush while the capture is still in flight is latched
        @(posedge clk); #1;
        burst = '{8'h5A};
        send_burst();
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        wait_stream("flush_latch", 12, 0);

        // Flush with nothing buffered produces nothing
        pulse_flush();
        repeat (25) begin
            @(posedge clk); #1;
        end
        chk("flush_empty_bytes", got_q.size(), 0);
        chk("flush_empty_busy", busy, 0);
        chk("flush_empty_pkts", pkt_count, exp_pkts[15:0]);

        // Backpressure on the second payload byte
        s0 = stable_seen;
        hold = 0;
        burst = '{8'h10, 8'h20, 8'h30, 8'h40};
        send_burst();
        cyc = 0;
        while (((got_q.size() < exp_q.size()) || busy) && (cyc < 60)) begin
            @(posedge clk); #1;
            if ((got_q.size() == 3) && (hold < 3)) begin
                m_ready = 1'b0;
                hold++;
            end else begin
                m_ready = 1'b1;
            end
            cyc++;
        end
        m_ready = 1'b1;
        chk("bp_stalled", ((stable_seen - s0) >= 3), 1);
        wait_stream("bp", 10, 0);

        // Reset in the middle of the payload
        burst = '{8'h55, 8'h66, 8'h77, 8'h88};
        send_burst();
        cyc = 0;
        while ((got_q.size() < 3) && (cyc < 40)) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("rst_mid_reached", (cyc < 40), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_valid", m_valid, 0);
        chk("rst_mid_pkts", pkt_count, 0);
        chk("rst_mid_busy", busy, 0);
        got_q.delete();
        exp_q.delete();
        exp_pkts = 0;
        @(posedge clk); #1;
        burst = '{8'h11, 8'h22, 8'h33, 8'h44};
        send_burst();
        wait_stream("post_rst", 40, 0);

        // Back-to-back: two full packets preloaded
        for (int i = 0; i < 8; i++) burst.push_back(8'($urandom));
        send_burst();
        wait_stream("b2b", 80, 0);

        // Random bursts with random downstream readiness
        for (int k = 0; k < 6; k++) begin
            n = $urandom_range(1, 11);
            for (int i = 0; i < n; i++) burst.push_back(8'($urandom));
            send_burst();
            wait_stream("rand", 300, 1);
        end

        chk("rd_during_send", rd_in_send, 0);
        chk("rd_while_empty", rd_empty, 0);
        chk("empty_pops", empty_pops, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
